// File: rtl/wifi_uart_fc.sv
`default_nettype none
// ============================================================================
//  Module      : wifi_uart_fc_fifo
//  Description : First-word-fall-through FIFO with occupancy count. The head
//                entry is always visible on o_dout while o_empty is low.
//                A push is accepted on a full FIFO when a pop happens in the
//                same cycle; a pop on an empty FIFO is ignored.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                i_push, i_din       - write request and data
//                i_pop               - remove head (ignored when empty)
//                o_dout              - head of queue
//                o_level             - number of stored entries
//                o_empty, o_full     - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module wifi_uart_fc_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_din,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_dout,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic                         o_empty,
    output logic                         o_full
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == c_LW'(DEPTH));
    assign w_do_pop  = i_pop & ~w_empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + c_LW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_level <= r_level - c_LW'(1);
            end
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule

// ============================================================================
//  Module      : wifi_uart_fc
//  Description : UART for the WiFi module with TX/RX FIFOs, RTS/CTS hardware
//                flow control, sticky error flags and FIFO level reporting.
//                8N1-style framing with DATA_BITS data bits, no parity, one
//                stop bit.
//  Ports       : clk_clk, reset_reset        - clock, sync active-high reset
//                tx_data/tx_valid/tx_ready   - byte stream into TX FIFO
//                rx_data/rx_valid/rx_ready   - byte stream out of RX FIFO
//                tx_level, rx_level          - FIFO occupancy
//                err_clear                   - clears sticky error flags
//                rx_overrun, rx_frame_err    - sticky error flags
//                uart_rxd, uart_txd          - serial data pins
//                uart_cts_n, uart_rts_n      - flow-control pins
//  Revision    : 1.0 - initial release
// ============================================================================
module wifi_uart_fc #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int TX_DEPTH     = 16,
    parameter int RX_DEPTH     = 16,
    parameter int RTS_MARGIN   = 4
) (
    input  logic                            clk_clk,
    input  logic                            reset_reset,
    input  logic [DATA_BITS-1:0]            tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic [DATA_BITS-1:0]            rx_data,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic [$clog2(TX_DEPTH+1)-1:0]   tx_level,
    output logic [$clog2(RX_DEPTH+1)-1:0]   rx_level,
    input  logic                            err_clear,
    output logic                            rx_overrun,
    output logic                            rx_frame_err,
    input  logic                            uart_rxd,
    output logic                            uart_txd,
    input  logic                            uart_cts_n,
    output logic                            uart_rts_n
);

    localparam int c_CW   = $clog2(CLKS_PER_BIT);
    localparam int c_BW   = $clog2(DATA_BITS);
    localparam int c_RXLW = $clog2(RX_DEPTH + 1);

    localparam logic [c_CW-1:0]   c_CTR_LAST = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0]   c_CTR_HALF = c_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_BW-1:0]   c_BIT_LAST = c_BW'(DATA_BITS - 1);
    localparam logic [c_RXLW-1:0] c_RX_DEPTH = c_RXLW'(RX_DEPTH);
    localparam logic [c_RXLW-1:0] c_MARGIN   = c_RXLW'(RTS_MARGIN);

    // ------------------------------------------------------------------
    // Input synchronisers. Both idle high so a reset never looks like a
    // start bit or a CTS grant.
    // ------------------------------------------------------------------
    logic r_rxd_s1;
    logic r_rxd_s2;
    logic r_rxd_d;
    logic r_cts_s1;
    logic r_cts_s2;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_rxd_s1 <= 1'b1;
            r_rxd_s2 <= 1'b1;
            r_rxd_d  <= 1'b1;
            r_cts_s1 <= 1'b1;
            r_cts_s2 <= 1'b1;
        end else begin
            r_rxd_s1 <= uart_rxd;
            r_rxd_s2 <= r_rxd_s1;
            r_rxd_d  <= r_rxd_s2;
            r_cts_s1 <= uart_cts_n;
            r_cts_s2 <= r_cts_s1;
        end
    end

    // Holds tx_ready low while in reset and releases it the cycle after.
    logic r_run;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] w_tx_head;
    logic                 w_tx_empty;
    logic                 w_tx_full;
    logic                 w_tx_pop;
    logic                 w_tx_push;

    assign tx_ready  = r_run & ~w_tx_full;
    assign w_tx_push = tx_valid & tx_ready;

    wifi_uart_fc_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_tx_fifo (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .i_push  (w_tx_push),
        .i_din   (tx_data),
        .i_pop   (w_tx_pop),
        .o_dout  (w_tx_head),
        .o_level (tx_level),
        .o_empty (w_tx_empty),
        .o_full  (w_tx_full)
    );

    // ------------------------------------------------------------------
    // TX FSM. uart_txd is registered from the current state, so the pin
    // trails the state by one cycle; a write therefore reaches the pin two
    // edges after it is accepted.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    tx_state_t            r_tx_state;
    logic [c_CW-1:0]      r_tx_ctr;
    logic [c_BW-1:0]      r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_txd;
    logic                 w_tx_go;
    logic                 w_tx_ctr_done;

    assign w_tx_go       = ~w_tx_empty & ~r_cts_s2;
    assign w_tx_ctr_done = (r_tx_ctr == c_CTR_LAST);

    // The end of a stop bit doubles as the idle decision point so that
    // queued bytes follow each other with no idle gap.
    always_comb begin
        w_tx_pop = 1'b0;
        case (r_tx_state)
            TX_IDLE: w_tx_pop = w_tx_go;
            TX_STOP: w_tx_pop = w_tx_ctr_done & w_tx_go;
            default: w_tx_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_ctr   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_START: r_txd <= 1'b0;
                TX_DATA:  r_txd <= r_tx_shift[0];
                default:  r_txd <= 1'b1;
            endcase

            case (r_tx_state)
                TX_IDLE: begin
                    r_tx_ctr <= '0;
                    if (w_tx_go) begin
                        r_tx_state <= TX_START;
                        r_tx_shift <= w_tx_head;
                    end
                end
                TX_START: begin
                    if (w_tx_ctr_done) begin
                        r_tx_ctr   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_ctr <= r_tx_ctr + c_CW'(1);
                    end
                end
                TX_DATA: begin
                    if (w_tx_ctr_done) begin
                        r_tx_ctr   <= '0;
                        r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
                        if (r_tx_bit == c_BIT_LAST) begin
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_bit <= r_tx_bit + c_BW'(1);
                        end
                    end else begin
                        r_tx_ctr <= r_tx_ctr + c_CW'(1);
                    end
                end
                TX_STOP: begin
                    if (w_tx_ctr_done) begin
                        r_tx_ctr <= '0;
                        if (w_tx_go) begin
                            r_tx_state <= TX_START;
                            r_tx_shift <= w_tx_head;
                        end else begin
                            r_tx_state <= TX_IDLE;
                        end
                    end else begin
                        r_tx_ctr <= r_tx_ctr + c_CW'(1);
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign uart_txd = r_txd;

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic                 w_rx_empty;
    logic                 w_rx_full;
    logic                 w_rx_push;
    logic                 w_rx_pop;
    logic [DATA_BITS-1:0] r_rx_shift;

    assign rx_valid = ~w_rx_empty;
    assign w_rx_pop = rx_ready & ~w_rx_empty;

    wifi_uart_fc_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_rx_fifo (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .i_push  (w_rx_push),
        .i_din   (r_rx_shift),
        .i_pop   (rx_ready),
        .o_dout  (rx_data),
        .o_level (rx_level),
        .o_empty (w_rx_empty),
        .o_full  (w_rx_full)
    );

    // ------------------------------------------------------------------
    // RX FSM. RX_WAIT holds off after a framing error until the line is
    // back high, so a break is not decoded as a stream of frames.
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_WAIT  = 3'd4
    } rx_state_t;

    rx_state_t       r_rx_state;
    logic [c_CW-1:0] r_rx_ctr;
    logic [c_BW-1:0] r_rx_bit;
    logic            w_rx_fall;
    logic            w_rx_ctr_done;
    logic            w_rx_stop_smp;
    logic            w_ovr_set;
    logic            w_fe_set;

    assign w_rx_fall     = r_rxd_d & ~r_rxd_s2;
    assign w_rx_ctr_done = (r_rx_ctr == c_CTR_LAST);
    assign w_rx_stop_smp = (r_rx_state == RX_STOP) & w_rx_ctr_done;
    assign w_rx_push     = w_rx_stop_smp & r_rxd_s2 & (~w_rx_full | w_rx_pop);
    assign w_ovr_set     = w_rx_stop_smp & r_rxd_s2 & w_rx_full & ~w_rx_pop;
    assign w_fe_set      = w_rx_stop_smp & ~r_rxd_s2;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_ctr   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_ctr <= '0;
                    if (w_rx_fall) begin
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    // Half a bit in: a high line here was only a glitch.
                    if (r_rx_ctr == c_CTR_HALF) begin
                        r_rx_ctr <= '0;
                        r_rx_bit <= '0;
                        if (r_rxd_s2) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_state <= RX_DATA;
                        end
                    end else begin
                        r_rx_ctr <= r_rx_ctr + c_CW'(1);
                    end
                end
                RX_DATA: begin
                    if (w_rx_ctr_done) begin
                        r_rx_ctr   <= '0;
                        r_rx_shift <= {r_rxd_s2, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == c_BIT_LAST) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + c_BW'(1);
                        end
                    end else begin
                        r_rx_ctr <= r_rx_ctr + c_CW'(1);
                    end
                end
                RX_STOP: begin
                    if (w_rx_ctr_done) begin
                        r_rx_ctr <= '0;
                        if (r_rxd_s2) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_state <= RX_WAIT;
                        end
                    end else begin
                        r_rx_ctr <= r_rx_ctr + c_CW'(1);
                    end
                end
                RX_WAIT: begin
                    r_rx_ctr <= '0;
                    if (r_rxd_s2) begin
                        r_rx_state <= RX_IDLE;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a set event beats a simultaneous clear.
    // ------------------------------------------------------------------
    logic r_overrun;
    logic r_frame_err;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (err_clear) begin
                r_overrun <= 1'b0;
            end
            if (w_fe_set) begin
                r_frame_err <= 1'b1;
            end else if (err_clear) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign rx_overrun   = r_overrun;
    assign rx_frame_err = r_frame_err;

    // ------------------------------------------------------------------
    // RTS: ask the peer to stop once fewer than RTS_MARGIN slots are free.
    // ------------------------------------------------------------------
    logic [c_RXLW-1:0] w_rx_free;
    logic              r_rts_n;

    assign w_rx_free = c_RX_DEPTH - rx_level;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_rts_n <= 1'b1;
        end else begin
            r_rts_n <= (w_rx_free < c_MARGIN);
        end
    end

    assign uart_rts_n = r_rts_n;

endmodule
`default_nettype wire

// File: tb/tb_wifi_uart_fc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wifi_uart_fc
//  Description : Self-checking bench for wifi_uart_fc (CLKS_PER_BIT=8,
//                DATA_BITS=8, 16-deep FIFOs, RTS_MARGIN=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wifi_uart_fc;

    localparam int CPB    = 8;
    localparam int DB     = 8;
    localparam int TXD    = 16;
    localparam int RXD    = 16;
    localparam int MARGIN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [4:0] tx_level;
    logic [4:0] rx_level;
    logic       err_clear = 1'b0;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic       uart_rxd;
    logic       uart_txd;
    logic       uart_cts_n = 1'b0;
    logic       uart_rts_n;

    logic       loop = 1'b0;
    logic       rxd_drv = 1'b1;

    assign uart_rxd = loop ? uart_txd : rxd_drv;

    wifi_uart_fc #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .TX_DEPTH     (TXD),
        .RX_DEPTH     (RXD),
        .RTS_MARGIN   (MARGIN)
    ) dut (
        .clk_clk      (clk),
        .reset_reset  (rst),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_level     (tx_level),
        .rx_level     (rx_level),
        .err_clear    (err_clear),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err),
        .uart_rxd     (uart_rxd),
        .uart_txd     (uart_txd),
        .uart_cts_n   (uart_cts_n),
        .uart_rts_n   (uart_rts_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance n active edges and land 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serial frame as seen on the wire: start 0, data LSB first, stop bit.
    function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int k);
        if (k == 0) return 1'b0;
        if (k == DB + 1) return stop;
        return d[k-1];
    endfunction

    task automatic write_byte(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        for (int k = 0; k < DB + 2; k++) begin
            rxd_drv = frame_bit(d, stop, k);
            tick(CPB);
        end
        rxd_drv = 1'b1;
        tick(6);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_push;
        logic       exp_fe;
    } rx_vec_t;

    rx_vec_t    vecs[4];
    logic [7:0] model_q[$];
    logic [7:0] full_bytes[17];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int n_rx;
        int lvl0;
        int exp_lvl;
        logic [7:0] got;

        vecs[0] = '{data: 8'h5A, stop: 1'b1, exp_push: 1'b1, exp_fe: 1'b0};
        vecs[1] = '{data: 8'h81, stop: 1'b0, exp_push: 1'b0, exp_fe: 1'b1};
        vecs[2] = '{data: 8'hC3, stop: 1'b1, exp_push: 1'b1, exp_fe: 1'b0};
        vecs[3] = '{data: 8'h00, stop: 1'b0, exp_push: 1'b0, exp_fe: 1'b1};

        // ---------------- reset state ----------------
        tick(3);
        check("rst_txd",      32'(uart_txd), 1);
        check("rst_rts_n",    32'(uart_rts_n), 1);
        check("rst_tx_ready", 32'(tx_ready), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_tx_level", 32'(tx_level), 0);
        check("rst_rx_level", 32'(rx_level), 0);
        check("rst_errs",     32'({rx_overrun, rx_frame_err}), 0);
        rst = 1'b0;
        tick(1);
        check("rel_tx_ready", 32'(tx_ready), 1);
        check("rel_rts_n",    32'(uart_rts_n), 0);
        tick(4);

        // ---------------- TX waveform of 0xA5 ----------------
        write_byte(8'hA5);
        check("a5_level_after_write", 32'(tx_level), 1);
        check("a5_txd_n0", 32'(uart_txd), 1);
        tick(1);
        check("a5_level_at_start", 32'(tx_level), 0);
        check("a5_txd_n1", 32'(uart_txd), 1);
        tick(1);
        for (int i = 0; i < (DB + 2) * CPB; i++) begin
            check($sformatf("a5_bit_cyc%0d", i), 32'(uart_txd), 32'(frame_bit(8'hA5, 1'b1, i / CPB)));
            tick(1);
        end
        check("a5_idle_after", 32'(uart_txd), 1);

        // ---------------- CTS hold / release / mid-frame ----------------
        uart_cts_n = 1'b1;
        tick(4);
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        write_byte(8'h44);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (uart_txd !== 1'b1) bad++;
            tick(1);
        end
        check("cts_hold_txd_low_cycles", 32'(bad), 0);
        check("cts_hold_level", 32'(tx_level), 4);
        uart_cts_n = 1'b0;
        tick(1);
        check("cts_rel_m0", 32'(uart_txd), 1);
        tick(1);
        check("cts_rel_m1", 32'(uart_txd), 1);
        tick(1);
        check("cts_rel_m2", 32'(uart_txd), 1);
        tick(1);
        check("cts_rel_start", 32'(uart_txd), 0);
        check("cts_rel_level", 32'(tx_level), 3);
        bad = 0;
        for (int i = 0; i < (DB + 2) * CPB; i++) begin
            if (i == 20) uart_cts_n = 1'b1;
            if (uart_txd !== frame_bit(8'h11, 1'b1, i / CPB)) bad++;
            tick(1);
        end
        check("cts_mid_frame_bits_wrong", 32'(bad), 0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (uart_txd !== 1'b1) bad++;
            tick(1);
        end
        check("cts_mid_held_txd_low_cycles", 32'(bad), 0);
        check("cts_mid_held_level", 32'(tx_level), 3);
        uart_cts_n = 1'b0;
        tick(3 * (DB + 2) * CPB + 20);
        check("cts_drain_level", 32'(tx_level), 0);
        check("cts_drain_txd", 32'(uart_txd), 1);

        // ---------------- loopback back-to-back ----------------
        loop = 1'b1;
        write_byte(8'h00);
        write_byte(8'hFF);
        write_byte(8'h3C);
        check("lb_f1_start", 32'(uart_txd), 0);
        tick(79);
        check("lb_f1_stop", 32'(uart_txd), 1);
        tick(1);
        check("lb_f2_start_nogap", 32'(uart_txd), 0);
        tick(79);
        check("lb_f2_stop", 32'(uart_txd), 1);
        tick(1);
        check("lb_f3_start_nogap", 32'(uart_txd), 0);
        tick(100);
        check("lb_rx_level", 32'(rx_level), 3);
        check("lb_no_errs", 32'({rx_overrun, rx_frame_err}), 0);
        model_q = '{8'h00, 8'hFF, 8'h3C};
        for (int i = 0; i < 3; i++) begin
            check("lb_rx_valid", 32'(rx_valid), 1);
            check($sformatf("lb_rx_data%0d", i), 32'(rx_data), 32'(model_q.pop_front()));
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
        end
        check("lb_rx_empty", 32'(rx_level), 0);

        // ---------------- randomized loopback vs queue model ----------------
        n_rx = 0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    logic [7:0] d;
                    logic acc;
                    tick($urandom_range(0, 60));
                    d = 8'($urandom);
                    acc = tx_ready;
                    write_byte(d);
                    if (acc) model_q.push_back(d);
                end
            end
            begin
                int budget;
                logic rr;
                budget = 0;
                while (n_rx < 12 && budget < 4000) begin
                    rr = 1'($urandom_range(0, 1));
                    rx_ready = rr;
                    if (rr && rx_valid) begin
                        got = rx_data;
                        check("rand_model_nonempty", 32'(model_q.size() != 0), 1);
                        if (model_q.size() != 0) begin
                            check($sformatf("rand_rx_byte%0d", n_rx), 32'(got), 32'(model_q.pop_front()));
                        end
                        n_rx++;
                    end
                    tick(1);
                    budget++;
                end
                rx_ready = 1'b0;
            end
        join
        check("rand_rx_count", 32'(n_rx), 12);
        check("rand_no_errs", 32'({rx_overrun, rx_frame_err}), 0);
        loop = 1'b0;
        tick(10);

        // ---------------- table-driven RX frames ----------------
        for (int i = 0; i < 4; i++) begin
            lvl0 = int'(rx_level);
            send_frame(vecs[i].data, vecs[i].stop);
            check($sformatf("vec%0d_level", i), 32'(rx_level), 32'(lvl0 + int'(vecs[i].exp_push)));
            check($sformatf("vec%0d_valid", i), 32'(rx_valid), 32'(vecs[i].exp_push));
            check($sformatf("vec%0d_fe", i), 32'(rx_frame_err), 32'(vecs[i].exp_fe));
            if (rx_valid) begin
                check($sformatf("vec%0d_data", i), 32'(rx_data), 32'(vecs[i].data));
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end
            pulse_clear();
            check($sformatf("vec%0d_fe_cleared", i), 32'(rx_frame_err), 0);
        end

        // ---------------- 2-cycle glitch ----------------
        rxd_drv = 1'b0;
        tick(2);
        rxd_drv = 1'b1;
        tick(30);
        check("glitch_level", 32'(rx_level), 0);
        check("glitch_errs", 32'({rx_overrun, rx_frame_err}), 0);

        // ---------------- fill RX, RTS and overrun ----------------
        for (int i = 0; i < 17; i++) begin
            full_bytes[i] = 8'($urandom);
            send_frame(full_bytes[i], 1'b1);
            exp_lvl = (i + 1 > RXD) ? RXD : i + 1;
            check($sformatf("fill%0d_level", i + 1), 32'(rx_level), 32'(exp_lvl));
            check($sformatf("fill%0d_rts_n", i + 1), 32'(uart_rts_n), 32'((RXD - exp_lvl) < MARGIN));
            check($sformatf("fill%0d_overrun", i + 1), 32'(rx_overrun), 32'(i + 1 > RXD));
        end
        pulse_clear();
        check("fill_overrun_cleared", 32'(rx_overrun), 0);
        for (int i = 0; i < RXD; i++) begin
            check($sformatf("fill_pop%0d", i), 32'(rx_data), 32'(full_bytes[i]));
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
        end
        check("fill_drained", 32'(rx_level), 0);
        tick(2);
        check("fill_rts_n_low", 32'(uart_rts_n), 0);

        // ---------------- reset mid-frame ----------------
        for (int i = 0; i < 5; i++) send_frame(8'(8'h60 + i), 1'b1);
        check("mid_rx_level5", 32'(rx_level), 5);
        write_byte(8'h00);
        tick(30);
        check("mid_txd_in_frame", 32'(uart_txd), 0);
        rst = 1'b1;
        tick(1);
        check("mid_rst_txd",      32'(uart_txd), 1);
        check("mid_rst_tx_level", 32'(tx_level), 0);
        check("mid_rst_rx_level", 32'(rx_level), 0);
        check("mid_rst_rts_n",    32'(uart_rts_n), 1);
        check("mid_rst_tx_ready", 32'(tx_ready), 0);
        rst = 1'b0;
        tick(1);
        check("mid_rel_rts_n",    32'(uart_rts_n), 0);
        check("mid_rel_tx_ready", 32'(tx_ready), 1);
        check("mid_rel_rx_valid", 32'(rx_valid), 0);
        check("mid_rel_txd",      32'(uart_txd), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
